// File: rtl/irq_timer.sv
// irq_timer: memory-mapped 32-bit auto-reload timer with a level interrupt.
//   TH   0x40000000  reload value
//   TL   0x40000004  counter
//   TCON 0x40000008  [0] count enable, [1] interrupt enable, [2] overflow status
// Build option: define TIMER_PRESCALE_EN to add a 16-bit prescaler PRESC at 0x4000000C.
// Without it, every clk cycle is a count tick and 0x4000000C is unmapped.
module irq_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        Kernel,
  input  logic        IntAck,
  output logic        Interrupt
);

  localparam logic [31:0] AddrTh   = 32'h4000_0000;
  localparam logic [31:0] AddrTl   = 32'h4000_0004;
  localparam logic [31:0] AddrTcon = 32'h4000_0008;

  logic [31:0] thQ, thD;
  logic [31:0] tlQ, tlD;
  logic [2:0]  tconQ, tconD;
  logic        selTh, selTl, selTcon;
  logic        wrTh, wrTl, wrTcon;
  logic        tick, countTick, atMax, overflow;

  assign selTh   = (Address == AddrTh);
  assign selTl   = (Address == AddrTl);
  assign selTcon = (Address == AddrTcon);
  assign wrTh    = MemWrite & selTh;
  assign wrTl    = MemWrite & selTl;
  assign wrTcon  = MemWrite & selTcon;

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] AddrPresc = 32'h4000_000C;

  logic [15:0] prescQ, divQ;
  logic        selPresc, wrPresc;

  assign selPresc = (Address == AddrPresc);
  assign wrPresc  = MemWrite & selPresc;
  // Tick on the divider's terminal count, giving one tick every PRESC+1 cycles.
  assign tick     = (divQ == prescQ);

  // Prescaler register and free-running divider; a PRESC write restarts the divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescQ <= '0;
      divQ   <= '0;
    end else if (wrPresc) begin
      prescQ <= WriteData[15:0];
      divQ   <= '0;
    end else if (tick) begin
      divQ   <= '0;
    end else begin
      divQ   <= divQ + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign countTick = tick & tconQ[0];
  assign atMax     = (tlQ == 32'hFFFF_FFFF);
  // A bus write to TL discards that cycle's tick entirely, including its overflow.
  assign overflow  = countTick & atMax & ~wrTl;

  // Combinational register read-back; unmapped or idle reads return zero.
  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      if (selTh) begin
        ReadData = thQ;
      end else if (selTl) begin
        ReadData = tlQ;
      end else if (selTcon) begin
        ReadData = {29'd0, tconQ};
`ifdef TIMER_PRESCALE_EN
      end else if (selPresc) begin
        ReadData = {16'd0, prescQ};
`endif
      end
    end
  end

  // Next-state: bus writes beat counting; overflow beats any status clear.
  always_comb begin
    thD = wrTh ? WriteData : thQ;

    tlD = tlQ;
    if (wrTl) begin
      tlD = WriteData;
    end else if (countTick) begin
      tlD = atMax ? thQ : tlQ + 32'd1;
    end

    tconD = tconQ;
    if (wrTcon) begin
      tconD = WriteData[2:0];
    end else if (IntAck) begin
      tconD[2] = 1'b0;
    end
    if (overflow) begin
      tconD[2] = 1'b1;
    end
  end

  // Register state with immediate asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thQ   <= '0;
      tlQ   <= '0;
      tconQ <= '0;
    end else begin
      thQ   <= thD;
      tlQ   <= tlD;
      tconQ <= tconD;
    end
  end

  assign Interrupt = tconQ[1] & tconQ[2] & ~Kernel;

endmodule

// File: tb/tb_irq_timer.sv
// tb_irq_timer: directed stimulus for irq_timer with a behavioural reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_irq_timer;

  localparam logic [31:0] AddrTh    = 32'h4000_0000;
  localparam logic [31:0] AddrTl    = 32'h4000_0004;
  localparam logic [31:0] AddrTcon  = 32'h4000_0008;
  localparam logic [31:0] AddrPresc = 32'h4000_000C;
  localparam logic [31:0] AllOnes   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        Kernel = 1'b0;
  logic        IntAck = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Interrupt;

  int unsigned vecCount = 0;
  int unsigned missCount = 0;

  irq_timer dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Kernel    (Kernel),
    .IntAck    (IntAck),
    .Interrupt (Interrupt)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as separate named fields.
  logic [31:0] mTh = '0;
  logic [31:0] mTl = '0;
  bit          mEn = 1'b0;
  bit          mIe = 1'b0;
  bit          mStat = 1'b0;
`ifdef TIMER_PRESCALE_EN
  logic [15:0]     mPresc = '0;
  longint unsigned edgeNum = 0;
  longint unsigned prescBase = 0;
`endif

  always @(posedge clk or negedge reset) begin : model
    bit tk, cnt, ovf, wTh, wTl, wTcon;
`ifdef TIMER_PRESCALE_EN
    bit wPre;
`endif
    if (!reset) begin
      mTh   <= '0;
      mTl   <= '0;
      mEn   <= 1'b0;
      mIe   <= 1'b0;
      mStat <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      mPresc    <= '0;
      edgeNum   <= 0;
      prescBase <= 0;
`endif
    end else begin
      wTh   = MemWrite && (Address == AddrTh);
      wTl   = MemWrite && (Address == AddrTl);
      wTcon = MemWrite && (Address == AddrTcon);
`ifdef TIMER_PRESCALE_EN
      // Ticks land on edges a whole number of periods after the last restart.
      tk   = ((edgeNum + 1 - prescBase) % (longint'(mPresc) + 1)) == 0;
      wPre = MemWrite && (Address == AddrPresc);
      if (wPre) begin
        mPresc    <= WriteData[15:0];
        prescBase <= edgeNum + 1;
      end
      edgeNum <= edgeNum + 1;
`else
      tk = 1'b1;
`endif
      cnt = tk && mEn;
      ovf = cnt && (mTl == AllOnes) && !wTl;
      if (wTh) mTh <= WriteData;
      if (wTl) mTl <= WriteData;
      else if (cnt) mTl <= (mTl == AllOnes) ? mTh : mTl + 32'd1;
      if (wTcon) begin
        mEn <= WriteData[0];
        mIe <= WriteData[1];
      end
      if (ovf) mStat <= 1'b1;
      else if (wTcon) mStat <= WriteData[2];
      else if (IntAck) mStat <= 1'b0;
    end
  end

  function automatic logic [31:0] modelRead();
    if (!MemRead) return '0;
    case (Address)
      AddrTh:    return mTh;
      AddrTl:    return mTl;
      AddrTcon:  return {29'd0, mStat, mIe, mEn};
`ifdef TIMER_PRESCALE_EN
      AddrPresc: return {16'd0, mPresc};
`endif
      default:   return '0;
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    checkVal("model ReadData", ReadData, modelRead());
    checkVal("model Interrupt", {31'd0, Interrupt}, {31'd0, mIe & mStat & ~Kernel});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Address   = a;
    WriteData = d;
    step(1);
    MemWrite  = 1'b0;
  endtask

  task automatic expectRead(input string name, input logic [31:0] a, input logic [31:0] exp);
    MemRead = 1'b1;
    Address = a;
    #1;
    checkVal(name, ReadData, exp);
  endtask

  task automatic expectIrq(input string name, input logic exp);
    #1;
    checkVal(name, {31'd0, Interrupt}, {31'd0, exp});
  endtask

  initial begin
    // Reset state
    expectIrq("reset irq", 1'b0);
    expectRead("reset TCON", AddrTcon, 32'h0);
    step(2);
    reset = 1'b1;
    expectRead("reset TH", AddrTh, 32'h0);
    expectRead("reset TL", AddrTl, 32'h0);
    step(2);
    expectRead("TL holds when disabled", AddrTl, 32'h0);

    // Auto-reload and overflow
    busWrite(AddrTh, 32'hFFFF_FFFD);
    busWrite(AddrTl, 32'hFFFF_FFFD);
    busWrite(AddrTcon, 32'h3);
    expectRead("TL start", AddrTl, 32'hFFFF_FFFD);
    step(2);
    expectRead("TL at max", AddrTl, 32'hFFFF_FFFF);
    expectIrq("no irq before ovf", 1'b0);
    step(1);
    expectRead("TL reload", AddrTl, 32'hFFFF_FFFD);
    expectRead("TCON after ovf", AddrTcon, 32'h7);
    expectIrq("irq after ovf", 1'b1);

    // Kernel masking and IntAck (counting stopped, status kept)
    busWrite(AddrTcon, 32'h6);
    Kernel = 1'b1;
    expectIrq("kernel masks", 1'b0);
    Kernel = 1'b0;
    expectIrq("kernel unmasks", 1'b1);
    IntAck = 1'b1;
    step(1);
    IntAck = 1'b0;
    expectIrq("ack clears irq", 1'b0);
    expectRead("TCON after ack", AddrTcon, 32'h2);

    // IntAck coincident with overflow
    busWrite(AddrTl, AllOnes);
    busWrite(AddrTcon, 32'h3);
    IntAck = 1'b1;
    step(1);
    IntAck = 1'b0;
    expectRead("TCON ack+ovf", AddrTcon, 32'h7);
    expectIrq("irq stays ack+ovf", 1'b1);
    expectRead("TL reload ack+ovf", AddrTl, 32'hFFFF_FFFD);

    // TL write beats tick
    busWrite(AddrTl, 32'h1234_5678);
    expectRead("TL write wins", AddrTl, 32'h1234_5678);
    step(1);
    expectRead("TL increments", AddrTl, 32'h1234_5679);

    // IntAck with interrupts disabled only clears status
    busWrite(AddrTcon, 32'h5);
    expectIrq("ie off no irq", 1'b0);
    IntAck = 1'b1;
    step(1);
    IntAck = 1'b0;
    expectRead("ack without irq", AddrTcon, 32'h1);
    expectIrq("still no irq", 1'b0);
    expectRead("TL keeps counting", AddrTl, 32'h1234_567B);

    // Software set/clear of status
    busWrite(AddrTcon, 32'h4);
    expectRead("sw set status", AddrTcon, 32'h4);
    busWrite(AddrTcon, 32'h0);
    expectRead("sw clear status", AddrTcon, 32'h0);

    // TCON write coincident with overflow
    busWrite(AddrTl, AllOnes);
    busWrite(AddrTcon, 32'h1);
    busWrite(AddrTcon, 32'h2);
    expectRead("TCON wr+ovf", AddrTcon, 32'h6);
    expectIrq("irq wr+ovf", 1'b1);
    expectRead("TL reload wr+ovf", AddrTl, 32'hFFFF_FFFD);

    // Unmapped accesses
    busWrite(32'h4000_0010, 32'hDEAD_BEEF);
    expectRead("unmapped read", 32'h4000_0010, 32'h0);
    expectRead("TH untouched", AddrTh, 32'hFFFF_FFFD);
    MemRead = 1'b0;
    #1;
    checkVal("no read strobe", ReadData, 32'h0);

    // Asynchronous reset mid-count with interrupt pending
    busWrite(AddrTcon, 32'h7);
    step(2);
    reset = 1'b0;
    expectIrq("async rst irq", 1'b0);
    expectRead("async rst TL", AddrTl, 32'h0);
    expectRead("async rst TCON", AddrTcon, 32'h0);
    reset = 1'b1;
    step(1);
    expectRead("TH after rst", AddrTh, 32'h0);
    expectIrq("no irq after rst", 1'b0);

`ifdef TIMER_PRESCALE_EN
    busWrite(AddrPresc, 32'h3);
    busWrite(AddrTl, 32'h0);
    busWrite(AddrTcon, 32'h1);
    expectRead("PRESC read", AddrPresc, 32'h3);
    step(12);
    expectRead("TL with prescale", AddrTl, 32'h3);
`else
    busWrite(AddrPresc, 32'h3);
    expectRead("PRESC unmapped", AddrPresc, 32'h0);
    busWrite(AddrTl, 32'h0);
    busWrite(AddrTcon, 32'h1);
    step(12);
    expectRead("TL every cycle", AddrTl, 32'd12);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/irq_timer.md
IRQ_TIMER -- requirements
Module: irq_timer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have the port MemRead, input, 1 bit, the data-bus read strobe.
REQ-004 The block SHALL have the port MemWrite, input, 1 bit, the data-bus write strobe.
REQ-005 The block SHALL have the port Address, input, 32 bits, the data-bus byte address.
REQ-006 The block SHALL have the port WriteData, input, 32 bits, the data-bus write data.
REQ-007 The block SHALL have the port ReadData, output, 32 bits, the register read data.
REQ-008 The block SHALL have the port Kernel, input, 1 bit, CPU in kernel mode; masks Interrupt.
REQ-009 The block SHALL have the port IntAck, input, 1 bit, one-cycle pulse when the CPU redirects PC to the interrupt vector.
REQ-010 The block SHALL have the port Interrupt, output, 1 bit, the interrupt request to the CPU control decoder.

Function
REQ-011 The block SHALL map TH at 0x40000000, TL at 0x40000004 and TCON at 0x40000008, with TCON[0] = count enable, TCON[1] = interrupt enable, TCON[2] = status, and TCON[31:3] reading 0.
REQ-012 ReadData SHALL be combinational: the addressed register when MemRead=1 and the address is mapped, otherwise 32'h0.
REQ-013 When MemWrite=1 and the address is mapped, the block SHALL load the register from WriteData on the next edge; unmapped writes SHALL be ignored.
REQ-014 On each count tick with TCON[0]=1: if TL=32'hFFFFFFFF, then TL<=TH and TCON[2]<=1; otherwise TL<=TL+1 (32-bit unsigned).
REQ-015 With TCON[0]=0, TL SHALL hold its value.
REQ-016 Interrupt SHALL be TCON[1] & TCON[2] & ~Kernel, combinational, level-held until cleared.
REQ-017 IntAck=1 SHALL clear TCON[2] on the next edge.
REQ-018 A software write of 0 to TCON[2] SHALL clear it; a software write of 1 SHALL set it.
REQ-019 Overflow in the same cycle as IntAck or a software clear SHALL leave TCON[2]=1 (overflow wins).
REQ-020 A bus write to TL in the same cycle as a tick SHALL win; the increment/reload is discarded for that cycle.
REQ-021 A bus write to TCON in the same cycle as an overflow SHALL update TCON[1:0] from WriteData and leave TCON[2]=1.
REQ-022 IntAck while Interrupt=0 SHALL clear TCON[2] and have no other effect.

Reset
REQ-023 On reset low, TH, TL and TCON SHALL become 0 immediately, independent of clk; Interrupt=0 and ReadData=0 unless MemRead is applied to a mapped address.
REQ-024 Reset asserted mid-count SHALL abort counting with no pending interrupt retained after release.

Configuration
REQ-025 When TIMER_PRESCALE_EN is defined, a 16-bit PRESC register SHALL be mapped at 0x4000000C and a tick SHALL occur once every PRESC+1 clk cycles via an internal 16-bit divider that resets to 0 and restarts when PRESC is written.
REQ-026 When TIMER_PRESCALE_EN is undefined, every clk cycle SHALL be a tick and 0x4000000C SHALL be unmapped (read 0, writes ignored).

Verification
REQ-027 TH=0xFFFFFFFD, TL=0xFFFFFFFD, TCON=3 -> TL reaches 0xFFFFFFFF after 2 ticks; the 3rd tick reloads TL=0xFFFFFFFD and sets status, Interrupt=1 in the following cycle.
REQ-028 Interrupt pending, Kernel=1 -> Interrupt=0; Kernel back to 0 -> Interrupt=1; IntAck pulse -> Interrupt=0 the next cycle.
REQ-029 IntAck in the same cycle as an overflow -> TCON reads 0x7 afterwards and Interrupt stays 1.
REQ-030 Writing TL=0x12345678 on the same cycle as a tick -> TL reads 0x12345678, then 0x12345679 one tick later.
REQ-031 Reset pulsed low asynchronously mid-count with Interrupt=1 -> all registers and Interrupt read 0 before the next clk edge.
REQ-032 With TIMER_PRESCALE_EN defined, PRESC=3 -> TL increments every 4 clk cycles; reading 0x4000000C without the macro returns 0.
